reg_bus_sequencer: RTL and testbench

//  Shares one 8-bit data bus between NUM_REGS 4-bit-sliced D-registers and sequences

---
 rtl/reg_bus_sequencer.sv | 165 ++++++++++++++++
 tb/tb_reg_bus_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_sequencer.sv
// Shared-bus register transfer sequencer: round-robin grant, then DRIVE/LOAD/DONE.
// Optional BUS_CHECK_EN adds err output and a short-cut for degenerate transfers.
//
// Ports:
//   CLK        clock, rising edge
//   CLR        synchronous active-high reset
//   req_valid  per-requester request
//   req_src    packed source indices, slice r for requester r
//   req_dst    packed destination indices, slice r for requester r
//   req_ready  one-hot accept, IDLE only
//   oe_n       active-low output enable per register
//   ld_n       active-low load enable per register
//   busy       high outside IDLE
//   done       one-cycle completion pulse
//   done_id    requester index of the completed transfer
//   err        (BUS_CHECK_EN only) degenerate transfer flag, valid with done
module reg_bus_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int NUM_REQ  = 2,
    parameter int IDX_W    = 2,
    parameter int REQ_W    = 1
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_src,
    input  logic [NUM_REQ*IDX_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REGS-1:0]      oe_n,
    output logic [NUM_REGS-1:0]      ld_n,
    output logic                     busy,
    output logic                     done,
    output logic [REQ_W-1:0]         done_id
`ifdef BUS_CHECK_EN
    ,
    output logic                     err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_src;
    logic [IDX_W-1:0] r_dst;
    logic [REQ_W-1:0] r_gid;
    logic [REQ_W-1:0] r_ptr;

    logic             w_found;
    logic [REQ_W-1:0] w_gnt;
    logic [IDX_W-1:0] w_gsrc;
    logic [IDX_W-1:0] w_gdst;
    logic             w_accept;
    logic             w_bad;

`ifdef BUS_CHECK_EN
    logic             r_bad;
`endif

    // Round-robin search starting at the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_gnt   = '0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_gnt   = REQ_W'(j);
            end
        end
    end

    assign w_gsrc = req_src[int'(w_gnt)*IDX_W +: IDX_W];
    assign w_gdst = req_dst[int'(w_gnt)*IDX_W +: IDX_W];

    // No command is taken while CLR is high, so ready is withheld too.
    assign w_accept = (r_state == S_IDLE) && w_found && !CLR;

`ifdef BUS_CHECK_EN
    assign w_bad = (w_gsrc == w_gdst)
                || (int'(w_gsrc) >= NUM_REGS)
                || (int'(w_gdst) >= NUM_REGS);
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_bad ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: w_next = S_LOAD;
            S_LOAD:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
`ifdef BUS_CHECK_EN
            r_bad   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src <= w_gsrc;
                r_dst <= w_gdst;
                r_gid <= w_gnt;
`ifdef BUS_CHECK_EN
                r_bad <= w_bad;
`endif
                if (int'(w_gnt) == NUM_REQ - 1) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gnt + 1'b1;
                end
            end
        end
    end

    // Enables come only from state and the latched command.
    // ld_n is also held off while CLR is high so the reset edge never loads.
    always_comb begin
        oe_n = '1;
        ld_n = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (((r_state == S_DRIVE) || (r_state == S_LOAD))
                && (r_src == IDX_W'(i))) begin
                oe_n[i] = 1'b0;
            end
            if ((r_state == S_LOAD) && !CLR && (r_dst == IDX_W'(i))) begin
                ld_n[i] = 1'b0;
            end
        end
    end

    assign req_ready = w_accept ? (NUM_REQ'(1) << w_gnt) : '0;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign done_id   = done ? r_gid : '0;

`ifdef BUS_CHECK_EN
    assign err = done && r_bad;
`endif

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: directed table, corner sequences, and
// randomized traffic against a cycle-schedule reference model.
module tb_reg_bus_sequencer;

    logic       CLK;
    logic       CLR;
    logic [1:0] req_valid;
    logic [3:0] req_src;
    logic [3:0] req_dst;
    logic [1:0] req_ready;
    logic [3:0] oe_n;
    logic [3:0] ld_n;
    logic       busy;
    logic       done;
    logic [0:0] done_id;
`ifdef BUS_CHECK_EN
    logic       err;
`endif

    reg_bus_sequencer #(
        .NUM_REGS(4),
        .NUM_REQ (2),
        .IDX_W   (2),
        .REQ_W   (1)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .req_valid(req_valid),
        .req_src  (req_src),
        .req_dst  (req_dst),
        .req_ready(req_ready),
        .oe_n     (oe_n),
        .ld_n     (ld_n),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id)
`ifdef BUS_CHECK_EN
        ,
        .err      (err)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic c, input logic [1:0] v,
                       input logic [1:0] s0, input logic [1:0] d0,
                       input logic [1:0] s1, input logic [1:0] d1);
        @(posedge CLK);
        #1;
        CLR       = c;
        req_valid = v;
        req_src   = {s1, s0};
        req_dst   = {d1, d0};
        #1;
    endtask

    typedef struct {
        logic       clr;
        logic [1:0] v;
        logic [1:0] s0, d0, s1, d1;
        logic       chk;
        logic [1:0] rdy;
        logic [3:0] oe, ld;
        logic       bsy, dn, id;
    } vec_t;

    function automatic vec_t mk(
        logic c, logic [1:0] v, logic [1:0] s0, logic [1:0] d0,
        logic [1:0] s1, logic [1:0] d1, logic k, logic [1:0] rdy,
        logic [3:0] oe, logic [3:0] ld, logic bsy, logic dn, logic id);
        vec_t x;
        x.clr = c;  x.v = v;
        x.s0 = s0;  x.d0 = d0;
        x.s1 = s1;  x.d1 = d1;
        x.chk = k;  x.rdy = rdy;
        x.oe = oe;  x.ld = ld;
        x.bsy = bsy; x.dn = dn; x.id = id;
        return x;
    endfunction

    vec_t tbl[17];

    // Reference model state: schedule relative to accept cycle.
    bit         m_act;
    int         m_ph;
    int         m_g;
    int         m_src;
    int         m_dst;
    bit         m_bad;
    int         m_ptr;
    int         gq[$];

    logic [1:0] rv;
    logic [1:0] rs[2];
    logic [1:0] rd[2];
    logic [1:0] prev_acc;

    initial begin
        CLR       = 1'b1;
        req_valid = '0;
        req_src   = '0;
        req_dst   = '0;

        tbl[0]  = mk(1,2'b00,0,0,0,0, 0,2'b00,4'hF,4'hF,0,0,0);
        tbl[1]  = mk(1,2'b00,0,0,0,0, 1,2'b00,4'hF,4'hF,0,0,0);
        tbl[2]  = mk(0,2'b01,1,3,0,0, 1,2'b01,4'hF,4'hF,0,0,0);
        tbl[3]  = mk(0,2'b00,1,3,0,0, 1,2'b00,4'b1101,4'hF,1,0,0);
        tbl[4]  = mk(0,2'b00,1,3,0,0, 1,2'b00,4'b1101,4'b0111,1,0,0);
        tbl[5]  = mk(0,2'b00,1,3,0,0, 1,2'b00,4'hF,4'hF,1,1,0);
        tbl[6]  = mk(0,2'b00,1,3,0,0, 1,2'b00,4'hF,4'hF,0,0,0);
        tbl[7]  = mk(1,2'b11,0,1,2,3, 1,2'b00,4'hF,4'hF,0,0,0);
        tbl[8]  = mk(0,2'b11,0,1,2,3, 1,2'b01,4'hF,4'hF,0,0,0);
        tbl[9]  = mk(0,2'b10,0,1,2,3, 1,2'b00,4'b1110,4'hF,1,0,0);
        tbl[10] = mk(0,2'b10,0,1,2,3, 1,2'b00,4'b1110,4'b1101,1,0,0);
        tbl[11] = mk(0,2'b11,0,1,2,3, 1,2'b00,4'hF,4'hF,1,1,0);
        tbl[12] = mk(0,2'b11,0,1,2,3, 1,2'b10,4'hF,4'hF,0,0,0);
        tbl[13] = mk(0,2'b01,0,1,2,3, 1,2'b00,4'b1011,4'hF,1,0,0);
        tbl[14] = mk(0,2'b01,0,1,2,3, 1,2'b00,4'b1011,4'b0111,1,0,0);
        tbl[15] = mk(0,2'b11,0,1,2,3, 1,2'b00,4'hF,4'hF,1,1,1);
        tbl[16] = mk(0,2'b11,0,1,2,3, 1,2'b01,4'hF,4'hF,0,0,0);

        for (int n = 0; n < 17; n++) begin
            cyc(tbl[n].clr, tbl[n].v, tbl[n].s0, tbl[n].d0,
                tbl[n].s1, tbl[n].d1);
            if (tbl[n].chk) begin
                chk($sformatf("tbl%0d_ready", n), req_ready, tbl[n].rdy);
                chk($sformatf("tbl%0d_oe_n", n), oe_n, tbl[n].oe);
                chk($sformatf("tbl%0d_ld_n", n), ld_n, tbl[n].ld);
                chk($sformatf("tbl%0d_busy", n), busy, tbl[n].bsy);
                chk($sformatf("tbl%0d_done", n), done, tbl[n].dn);
                if (tbl[n].dn)
                    chk($sformatf("tbl%0d_id", n), done_id, tbl[n].id);
            end
        end

        // Reset during LOAD abandons the transfer and resets priority.
        cyc(1, 2'b00, 0,0,0,0);
        cyc(0, 2'b01, 1,3,0,2);
        chk("clrload_ready0", req_ready, 2'b01);
        cyc(0, 2'b11, 1,3,0,2);
        chk("clrload_drive_oe", oe_n, 4'b1101);
        cyc(1, 2'b11, 1,3,0,2);
        chk("clrload_load_oe", oe_n, 4'b1101);
        chk("clrload_load_ld", ld_n, 4'hF);
        cyc(0, 2'b11, 1,3,0,2);
        chk("clrload_after_busy", busy, 1'b0);
        chk("clrload_after_done", done, 1'b0);
        chk("clrload_after_oe", oe_n, 4'hF);
        chk("clrload_after_ld", ld_n, 4'hF);
        chk("clrload_after_ready", req_ready, 2'b01);

        // src == dst transfer.
        cyc(1, 2'b00, 0,0,0,0);
        cyc(0, 2'b01, 2,2,0,0);
        chk("same_ready", req_ready, 2'b01);
        cyc(0, 2'b00, 2,2,0,0);
`ifdef BUS_CHECK_EN
        chk("same_c1_done", done, 1'b1);
        chk("same_c1_err", err, 1'b1);
        chk("same_c1_oe", oe_n, 4'hF);
        chk("same_c1_ld", ld_n, 4'hF);
        cyc(0, 2'b00, 2,2,0,0);
        chk("same_c2_busy", busy, 1'b0);
        chk("same_c2_oe", oe_n, 4'hF);
        chk("same_c2_ld", ld_n, 4'hF);
`else
        chk("same_c1_done", done, 1'b0);
        chk("same_c1_oe", oe_n, 4'b1011);
        cyc(0, 2'b00, 2,2,0,0);
        chk("same_c2_oe", oe_n, 4'b1011);
        chk("same_c2_ld", ld_n, 4'b1011);
        cyc(0, 2'b00, 2,2,0,0);
        chk("same_c3_done", done, 1'b1);
        chk("same_c3_id", done_id, 1'b0);
`endif

        // Randomized traffic against the schedule model.
        cyc(1, 2'b00, 0,0,0,0);
        m_act    = 0;
        m_ph     = 0;
        m_ptr    = 0;
        rv       = '0;
        prev_acc = '0;
        for (int r = 0; r < 2; r++) begin
            rs[r] = '0;
            rd[r] = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            logic       clr;
            logic [1:0] e_rdy;
            logic [3:0] e_oe, e_ld;
            logic       e_bsy, e_dn;
            int         g;

            for (int r = 0; r < 2; r++) begin
                if (rv[r] && prev_acc[r]) rv[r] = 1'b0;
                if (rv[r] && $urandom_range(0, 19) == 0) begin
                    rv[r] = 1'b0;
                end else if (!rv[r] && $urandom_range(0, 2) == 0) begin
                    rv[r] = 1'b1;
                    rs[r] = 2'($urandom_range(0, 3));
                    rd[r] = 2'($urandom_range(0, 3));
                end
            end
            clr = ($urandom_range(0, 99) == 0);
            cyc(clr, rv, rs[0], rd[0], rs[1], rd[1]);

            e_rdy = '0; e_oe = 4'hF; e_ld = 4'hF;
            e_bsy = 0;  e_dn = 0;    g = -1;
            if (m_act) begin
                e_bsy = 1;
                if (m_bad) begin
                    e_dn = (m_ph == 1);
                end else begin
                    if (m_ph <= 2) e_oe[m_src] = 1'b0;
                    if (m_ph == 2 && !clr) e_ld[m_dst] = 1'b0;
                    e_dn = (m_ph == 3);
                end
            end else if (!clr) begin
                for (int k = 0; k < 2; k++) begin
                    int r;
                    r = (m_ptr + k) % 2;
                    if (g < 0 && rv[r]) g = r;
                end
                if (g >= 0) e_rdy[g] = 1'b1;
            end

            chk("rnd_ready", req_ready, e_rdy);
            chk("rnd_oe_n", oe_n, e_oe);
            chk("rnd_ld_n", ld_n, e_ld);
            chk("rnd_busy", busy, e_bsy);
            chk("rnd_done", done, e_dn);
            chk("rnd_oe_onehot", 32'($countones(~oe_n) <= 1), 1);
            chk("rnd_ld_onehot", 32'($countones(~ld_n) <= 1), 1);
            if (e_dn) begin
                chk("rnd_done_id", done_id, m_g);
`ifdef BUS_CHECK_EN
                chk("rnd_err", err, m_bad);
`endif
            end
            if (done) begin
                if (gq.size() == 0) begin
                    chk("rnd_spurious_done", 1, 0);
                end else begin
                    chk("rnd_sb_id", done_id, gq.pop_front());
                end
            end

            prev_acc = clr ? 2'b00 : (req_ready & rv);
            if (clr) begin
                m_act = 0;
                m_ptr = 0;
                gq.delete();
            end else if (m_act) begin
                m_ph++;
                if (m_ph >= (m_bad ? 2 : 4)) m_act = 0;
            end else if (g >= 0) begin
                m_act = 1;
                m_ph  = 1;
                m_g   = g;
                m_src = int'(rs[g]);
                m_dst = int'(rd[g]);
`ifdef BUS_CHECK_EN
                m_bad = (rs[g] == rd[g]);
`else
                m_bad = 0;
`endif
                m_ptr = (g + 1) % 2;
                gq.push_back(g);
            end
        end
        chk("rnd_sb_leftover", 32'(gq.size() <= 1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
